// File: rtl/lsu_ctrl_if.sv
// Request/response handshake and data-memory port of the load/store controller.
// slave: the controller's view; master: the execute stage + memory side.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  mem_bhw;
    logic        mem_sgn;
    logic        mem_wr;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_bhw, mem_sgn, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_bhw, mem_sgn, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller for the 4 KB big-endian data memory.
// Define LSU_MISALIGN_SPLIT_EN to execute misaligned half/word accesses as byte sequences.
module lsu_ctrl (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  io_bus
);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {StIdle, StAccess, StResp, StSplit} state_e;
`else
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
`endif

    state_e      r_state, w_state_next;
    logic        r_wr;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [12:0] w_bytes_m1;
    logic [12:0] w_end;
    logic        w_misal;
    logic        w_err;
    logic        w_accept;

    // Last byte address of the request; bit 12 set means it runs past 0xFFF.
    assign w_bytes_m1 = (io_bus.req_size == 2'b11) ? 13'd3 :
                        (io_bus.req_size == 2'b01) ? 13'd1 : 13'd0;
    assign w_end      = {1'b0, io_bus.req_addr[11:0]} + w_bytes_m1;
    assign w_misal    = ((io_bus.req_size == 2'b01) && io_bus.req_addr[0]) ||
                        ((io_bus.req_size == 2'b11) && (io_bus.req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_err      = (io_bus.req_size == 2'b10) || (|io_bus.req_addr[31:12]) || w_end[12];
`else
    assign w_err      = (io_bus.req_size == 2'b10) || (|io_bus.req_addr[31:12]) || w_end[12] ||
                        w_misal;
`endif
    assign w_accept   = (r_state == StIdle) && io_bus.req_valid;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]  r_cnt;
    logic [23:0] r_asm;
    logic [1:0]  w_last_idx;
    logic [1:0]  w_sel;
    logic        w_last;
    logic [7:0]  w_split_byte;
    logic [31:0] w_asm;
    logic [31:0] w_asm_ext;

    assign w_last_idx   = r_size[1] ? 2'd3 : 2'd1;
    assign w_sel        = w_last_idx - r_cnt;
    assign w_last       = (r_cnt == w_last_idx);
    // Byte k of an N-byte value counts from the MSB end.
    assign w_split_byte = r_wdata[{w_sel, 3'b000} +: 8];
    assign w_asm        = {r_asm, io_bus.mem_rdata[7:0]};
    assign w_asm_ext    = r_size[1] ? w_asm :
                          r_uns     ? {16'h0000, w_asm[15:0]} :
                                      {{16{w_asm[15]}}, w_asm[15:0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        io_bus.req_ready = 1'b0;
        io_bus.rsp_valid = 1'b0;
        io_bus.rsp_rdata = 32'h0;
        io_bus.rsp_err   = 1'b0;
        io_bus.mem_bhw   = 2'b00;
        io_bus.mem_sgn   = 1'b0;
        io_bus.mem_wr    = 1'b0;
        io_bus.mem_addr  = 12'h000;
        io_bus.mem_wdata = 32'h0;
        unique case (r_state)
            StIdle: begin
                io_bus.req_ready = 1'b1;
                if (io_bus.req_valid) begin
                    if (w_err) begin
                        w_state_next = StResp;
`ifdef LSU_MISALIGN_SPLIT_EN
                    end else if (w_misal) begin
                        w_state_next = StSplit;
`endif
                    end else begin
                        w_state_next = StAccess;
                    end
                end
            end
            StAccess: begin
                io_bus.mem_bhw   = r_size;
                io_bus.mem_sgn   = r_uns;
                io_bus.mem_wr    = r_wr;
                io_bus.mem_addr  = r_addr;
                io_bus.mem_wdata = r_wdata;
                w_state_next     = StResp;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            StSplit: begin
                io_bus.mem_sgn   = 1'b1;
                io_bus.mem_wr    = r_wr;
                io_bus.mem_addr  = r_addr + {10'b0, r_cnt};
                io_bus.mem_wdata = {24'h0, w_split_byte};
                if (w_last) begin
                    w_state_next = StResp;
                end
            end
`endif
            StResp: begin
                io_bus.rsp_valid = 1'b1;
                io_bus.rsp_rdata = r_rdata;
                io_bus.rsp_err   = r_err;
                if (io_bus.rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= 12'h000;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_cnt   <= 2'd0;
            r_asm   <= 24'h0;
`endif
        end else if (w_accept) begin
            r_wr    <= io_bus.req_wr;
            r_size  <= io_bus.req_size;
            r_uns   <= io_bus.req_unsigned;
            r_addr  <= io_bus.req_addr[11:0];
            r_wdata <= io_bus.req_wdata;
            r_rdata <= 32'h0;
            r_err   <= w_err;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_cnt   <= 2'd0;
            r_asm   <= 24'h0;
`endif
        end else if ((r_state == StAccess) && !r_wr) begin
            r_rdata <= io_bus.mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        end else if (r_state == StSplit) begin
            r_cnt <= r_cnt + 2'd1;
            r_asm <= w_asm[23:0];
            if (w_last && !r_wr) begin
                r_rdata <= w_asm_ext;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: byte-array memory behind the DUT, and a
// byte-level reference model of the spec's access rules for randomized requests.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_ctrl_if bus_if ();

    lsu_ctrl u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_if)
    );

    logic [7:0] env_mem [4096] = '{default: 8'h00};
    logic [7:0] ref_mem [4096] = '{default: 8'h00};
    int n_cmp = 0;
    int n_bad = 0;
    int wr_total = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Memory behind the DUT: combinational extended read, write on rising clk.
    logic [7:0]  rb0, rb1, rb2, rb3;
    logic [31:0] env_rdata;
    always_comb begin
        rb0 = env_mem[bus_if.mem_addr];
        rb1 = env_mem[bus_if.mem_addr + 12'd1];
        rb2 = env_mem[bus_if.mem_addr + 12'd2];
        rb3 = env_mem[bus_if.mem_addr + 12'd3];
        case (bus_if.mem_bhw)
            2'b00:   env_rdata = bus_if.mem_sgn ? {24'h0, rb0} : {{24{rb0[7]}}, rb0};
            2'b01:   env_rdata = bus_if.mem_sgn ? {16'h0, rb0, rb1} : {{16{rb0[7]}}, rb0, rb1};
            default: env_rdata = {rb0, rb1, rb2, rb3};
        endcase
    end
    assign bus_if.mem_rdata = env_rdata;

    always @(posedge clk) begin
        if (bus_if.mem_wr) begin
            wr_total = wr_total + 1;
            case (bus_if.mem_bhw)
                2'b00: env_mem[bus_if.mem_addr] <= bus_if.mem_wdata[7:0];
                2'b01: begin
                    env_mem[bus_if.mem_addr]         <= bus_if.mem_wdata[15:8];
                    env_mem[bus_if.mem_addr + 12'd1] <= bus_if.mem_wdata[7:0];
                end
                default: begin
                    env_mem[bus_if.mem_addr]         <= bus_if.mem_wdata[31:24];
                    env_mem[bus_if.mem_addr + 12'd1] <= bus_if.mem_wdata[23:16];
                    env_mem[bus_if.mem_addr + 12'd2] <= bus_if.mem_wdata[15:8];
                    env_mem[bus_if.mem_addr + 12'd3] <= bus_if.mem_wdata[7:0];
                end
            endcase
        end
    end

    // Reference: outcome of one request from the access rules, updating ref_mem.
    task automatic model(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata,
                         output int lat, output int nwr);
        int nb;
        int a;
        logic mis;
        logic [31:0] v;
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b11) ? 4 : 0;
        a = int'(addr[11:0]);
        err = (size == 2'b10) || (addr[31:12] != 20'h0) || (a + nb - 1 > 4095);
        mis = (nb != 0) && ((a % nb) != 0);
        if (mis && !SplitEn) err = 1'b1;
        rdata = 32'h0;
        lat = 0;
        nwr = 0;
        if (!err) begin
            lat = mis ? nb : 1;
            if (wr) begin
                nwr = lat;
                for (int i = 0; i < nb; i++) ref_mem[a + i] = 8'(wdata >> (8 * (nb - 1 - i)));
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v = (v << 8) | {24'h0, ref_mem[a + i]};
                if (nb < 4 && !uns && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                rdata = v;
            end
        end
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold);
        logic exp_err;
        logic [31:0] exp_rdata;
        int exp_lat, exp_nwr, lat, w0;
        model(wr, size, uns, addr, wdata, exp_err, exp_rdata, exp_lat, exp_nwr);
        @(negedge clk);
        check_eq({tag, ".ready"}, {31'h0, bus_if.req_ready}, 32'd1);
        bus_if.req_valid    = 1'b1;
        bus_if.req_wr       = wr;
        bus_if.req_size     = size;
        bus_if.req_unsigned = uns;
        bus_if.req_addr     = addr;
        bus_if.req_wdata    = wdata;
        bus_if.rsp_ready    = 1'b0;
        w0 = wr_total;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        lat = 0;
        while (!bus_if.rsp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, ".lat"}, lat, exp_lat);
        check_eq({tag, ".err"}, {31'h0, bus_if.rsp_err}, {31'h0, exp_err});
        check_eq({tag, ".rdata"}, bus_if.rsp_rdata, exp_rdata);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_eq({tag, ".hold_valid"}, {31'h0, bus_if.rsp_valid}, 32'd1);
            check_eq({tag, ".hold_ready"}, {31'h0, bus_if.req_ready}, 32'd0);
            check_eq({tag, ".hold_rdata"}, bus_if.rsp_rdata, exp_rdata);
        end
        @(negedge clk);
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rsp_ready = 1'b0;
        check_eq({tag, ".consumed"}, {31'h0, bus_if.rsp_valid}, 32'd0);
        check_eq({tag, ".nwr"}, wr_total - w0, exp_nwr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".req_ready"}, {31'h0, bus_if.req_ready}, 32'd1);
        check_eq({tag, ".rsp_valid"}, {31'h0, bus_if.rsp_valid}, 32'd0);
        check_eq({tag, ".rsp_rdata"}, bus_if.rsp_rdata, 32'h0);
        check_eq({tag, ".rsp_err"}, {31'h0, bus_if.rsp_err}, 32'd0);
        check_eq({tag, ".mem_wr"}, {31'h0, bus_if.mem_wr}, 32'd0);
        check_eq({tag, ".mem_addr"}, {20'h0, bus_if.mem_addr}, 32'h0);
        check_eq({tag, ".mem_ctl"}, {29'h0, bus_if.mem_bhw, bus_if.mem_sgn}, 32'h0);
        check_eq({tag, ".mem_wdata"}, bus_if.mem_wdata, 32'h0);
    endtask

    task automatic reset_mid_access();
        @(negedge clk);
        bus_if.req_valid    = 1'b1;
        bus_if.req_wr       = 1'b1;
        bus_if.req_size     = 2'b11;
        bus_if.req_unsigned = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        bus_if.req_addr     = 32'h0000_0101;
`else
        bus_if.req_addr     = 32'h0000_0100;
`endif
        bus_if.req_wdata    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        // First byte lands on the next edge; abort while the second is on the bus.
        @(posedge clk);
        ref_mem[12'h101] = 8'hDE;
`endif
        #1;
        check_eq("rst.pre_wr", {31'h0, bus_if.mem_wr}, 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst.mid");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int diffs;
        logic wr, uns;
        logic [1:0] size;
        logic [31:0] addr;
        int r;
        bus_if.req_valid    = 1'b0;
        bus_if.req_wr       = 1'b0;
        bus_if.req_size     = 2'b00;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_addr     = 32'h0;
        bus_if.req_wdata    = 32'h0;
        bus_if.rsp_ready    = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_req("st_w",    1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h1122_3344, 0);
        do_req("ld_w",    1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, 5);
        do_req("st_b",    1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_0080, 0);
        do_req("ld_bs",   1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0, 0);
        do_req("ld_bu",   1'b0, 2'b00, 1'b1, 32'h0000_0021, 32'h0, 1);
        do_req("ld_oob",  1'b0, 2'b11, 1'b0, 32'h0000_1000, 32'h0, 0);
        do_req("st_sz2",  1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0000_5555, 0);
        do_req("st_mis",  1'b1, 2'b11, 1'b0, 32'h0000_0031, 32'hA1B2_C3D4, 0);
        do_req("ld_hmis", 1'b0, 2'b01, 1'b0, 32'h0000_0033, 32'h0, 0);
        do_req("st_end",  1'b1, 2'b11, 1'b0, 32'h0000_0FFE, 32'h7777_7777, 0);
        do_req("ld_end",  1'b0, 2'b01, 1'b1, 32'h0000_0FFE, 32'h0, 0);

        for (int n = 0; n < 300; n++) begin
            wr  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 15));
            size = (r == 0) ? 2'b10 : (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : 2'b11;
            r = int'($urandom_range(0, 19));
            if (r == 0)      addr = 32'h0000_1000 + $urandom_range(0, 255);
            else if (r == 1) addr = $urandom | 32'h0010_0000;
            else if (r == 2) addr = 32'h0000_0FFC + $urandom_range(0, 3);
            else             addr = $urandom_range(0, 63);
            do_req("rnd", wr, size, uns, addr, $urandom, int'($urandom_range(0, 2)));
        end

        reset_mid_access();
        do_req("post_rst", 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 0);

        diffs = 0;
        for (int i = 0; i < 4096; i++) begin
            if (env_mem[i] !== ref_mem[i]) diffs++;
        end
        check_eq("mem.final", diffs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller sitting between the execute stage and the 4 KB data memory. Accepts one load or store request per handshake and drives the memory's size/sign/write/address/data port. Returns load data with sign or zero extension and flags illegal accesses. Optionally splits misaligned halfword and word accesses into sequential byte accesses.

## Interface
- No parameters. Memory size is fixed at 4 KB, byte-addressed, big-endian.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 11 word; 10 is illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0])
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  address error; no memory write occurred
- mem_bhw  out  2  access size to memory, same encoding as req_size
- mem_sgn  out  1  1 = memory zero-extends, 0 = memory sign-extends
- mem_wr  out  1  write strobe, sampled by memory on rising clk
- mem_addr  out  12  byte address to memory
- mem_wdata  out  32  right-justified write data
- mem_rdata  in  32  combinational read data, already extended per mem_bhw/mem_sgn

## Operation
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE: req_ready=1. On req_valid: latch request, run checks, go to ACCESS (aligned, legal), SPLIT (misaligned, legal, split enabled) or RESP with rsp_err=1.
- Error conditions, checked at accept: req_size=10; req_addr[31:12]!=0; req_addr + bytes - 1 > 0xFFF; misaligned (halfword addr[0]=1, word addr[1:0]!=0) when split disabled. Errors never touch memory.
- ACCESS: one cycle; mem_bhw=req_size, mem_sgn=req_unsigned, mem_addr=req_addr[11:0], mem_wdata=req_wdata, mem_wr=req_wr. Load data captured from mem_rdata at cycle end. Go to RESP.
- SPLIT: one byte per cycle, byte counter k from 0 to N-1 (N=2 half, 4 word); mem_bhw=00, mem_sgn=1, mem_addr=addr+k. Store byte k = bits [8N-1-8k -: 8] of req_wdata (big-endian: MSB at lowest address). Load bytes shift into an assembly register MSB-first. After byte N-1, extend assembled value to 32 bits per req_unsigned, go to RESP.
- RESP: rsp_valid=1, outputs stable; on rsp_ready go to IDLE. Store responses: rsp_rdata=0, rsp_err=0.
- All mem_* outputs are 0 outside ACCESS/SPLIT; mem_wr never high outside ACCESS/SPLIT.

## Timing
- Reset (rst=0): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, all mem_* = 0, counter and latches cleared. Reset mid-access aborts immediately; any partially written split store is not rolled back.
- Aligned: accept at edge E0, memory access cycle E0..E1, rsp_valid from E1. Minimum request-to-request: 3 cycles with rsp_ready tied high.
- Split: N memory cycles, rsp_valid after E_N.
- Error: rsp_valid one cycle after accept.
- req_valid while not IDLE is ignored (req_ready=0); requester must hold request until accepted.
- rsp_valid and rsp_ready in the same cycle: response consumed, IDLE next cycle; next request accepted no earlier than the following edge.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned halfword/word accesses inside the 4 KB range execute via SPLIT as above.
- Undefined: SPLIT state and byte counter are compiled out; misaligned accesses return rsp_err=1 with no memory access.

## Test plan
- Store word 0x11223344 to 0x010, load word 0x010 -> rsp_rdata=0x11223344, rsp_err=0, mem_wr high exactly one cycle.
- Store byte 0x80 to 0x021; load signed byte -> 0xFFFFFF80; unsigned byte -> 0x00000080; aligned load/store response 2 cycles after accept.
- Load word at 0x1000, store half with req_size=10 -> rsp_err=1, rsp_rdata=0, mem_wr never asserted.
- With LSU_MISALIGN_SPLIT_EN: store word 0xA1B2C3D4 to 0x031 -> four byte writes 0xA1@0x031, 0xB2@0x032, 0xC3@0x033, 0xD4@0x034; signed half load at 0x033 -> 0xFFFFC3D4. Without macro: same store -> rsp_err=1, memory unchanged.
- Word store at 0xFFE (split enabled) -> rsp_err=1, no write.
- Hold rsp_ready=0 for 5 cycles: rsp_valid/rsp_rdata stable, req_ready=0; assert rst mid-split -> all outputs return to reset values asynchronously.
